ddr4_app_arbiter: RTL and testbench

- Two-requester arbiter for one DDR4 MIG native app interface (one ddr4_N controller channel). Instanced per enabled channel between user logic and the controller.
- Round-robin arbitration with a bounded burst-hold. Holds a command until the controller accepts it, per MIG app rules.
- Routes in-order read returns back to the issuing requester through a tag FIFO.

---
 rtl/ddr4_app_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ddr4_app_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_app_arbiter.sv
// Two-requester round-robin arbiter for a DDR4 MIG native app interface.
// Holds a command until the controller takes it and routes in-order read
// returns back to the issuing requester through a small tag FIFO.
// TAG_DEPTH must be a power of two and at least 2.
module ddr4_app_arbiter #(
   parameter int unsigned ADDR_W    = 31,
   parameter int unsigned DATA_W    = 512,
   parameter int unsigned MASK_W    = 64,
   parameter int unsigned MAX_BURST = 8,
   parameter int unsigned TAG_DEPTH = 32
) (
   input  logic                  ddr4_ui_clk,
   input  logic                  ddr4_ui_clk_sync_rst,
   input  logic                  init_calib_complete,
   input  logic [1:0]            req,
   input  logic [1:0]            req_rd,
   input  logic [2*ADDR_W-1:0]   req_addr,
   input  logic [2*DATA_W-1:0]   req_wdata,
   input  logic [2*MASK_W-1:0]   req_wmask,
   output logic [1:0]            req_ack,
   output logic [DATA_W-1:0]     rsp_rd_data,
   output logic [1:0]            rsp_rd_valid,
   output logic                  app_en,
   output logic [2:0]            app_cmd,
   output logic [ADDR_W-1:0]     app_addr,
   output logic                  app_hi_pri,
   input  logic                  app_rdy,
   output logic [DATA_W-1:0]     app_wdf_data,
   output logic [MASK_W-1:0]     app_wdf_mask,
   output logic                  app_wdf_wren,
   output logic                  app_wdf_end,
   input  logic                  app_wdf_rdy,
   input  logic [DATA_W-1:0]     app_rd_data,
   input  logic                  app_rd_data_valid,
   output logic                  err_tag_underflow
);

   localparam int unsigned CNT_W  = $clog2(MAX_BURST + 1);
   localparam int unsigned PTR_W  = $clog2(TAG_DEPTH);
   localparam int unsigned TCNT_W = $clog2(TAG_DEPTH + 1);

   typedef enum logic {ST_CALIB, ST_RUN} state_e;

   state_e               state_q;
   logic                 owner_q, owner_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 lock_q, lock_d;
   logic                 wdf_done_q, wdf_done_d;
   logic [TAG_DEPTH-1:0] tag_mem_q;
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [TCNT_W-1:0]    tag_cnt_q;
   logic [1:0]           rsp_vld_q;
   logic [DATA_W-1:0]    rsp_data_q;
   logic                 err_q;

   logic eff, sel_vld, other, issue, is_rd, accept, push, pop, head;

   // Grant selection: lock pins the owner, otherwise round-robin with burst cap
   always_comb begin
      other   = ~owner_q;
      eff     = owner_q;
      sel_vld = 1'b0;
      if (lock_q) begin
         eff     = owner_q;
         sel_vld = 1'b1;
      end else if (req[owner_q] && !((cnt_q >= CNT_W'(MAX_BURST)) && req[other])) begin
         eff     = owner_q;
         sel_vld = 1'b1;
      end else if (req[other]) begin
         eff     = other;
         sel_vld = 1'b1;
      end
   end

   // Command/data issue toward the controller and requester handshake
   always_comb begin
      issue        = (state_q == ST_RUN) && sel_vld && req[eff];
      is_rd        = req_rd[eff];
      app_cmd      = is_rd ? 3'b001 : 3'b000;
      app_addr     = eff ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
      app_wdf_data = eff ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      app_wdf_mask = eff ? req_wmask[2*MASK_W-1:MASK_W] : req_wmask[MASK_W-1:0];
      // Read gating uses the registered count, ignoring a same-cycle pop
      app_en       = issue && (is_rd ? (tag_cnt_q < TCNT_W'(TAG_DEPTH))
                                     : (wdf_done_q || app_wdf_rdy));
      app_wdf_wren = issue && !is_rd && !wdf_done_q;
      app_wdf_end  = app_wdf_wren;
      accept       = app_en && app_rdy;
      req_ack      = accept ? (eff ? 2'b10 : 2'b01) : 2'b00;
      push         = accept && is_rd;
      pop          = app_rd_data_valid && (tag_cnt_q != '0);
      head         = tag_mem_q[rd_ptr_q];
   end

   // Next owner, burst count, lock and write-data-sent flag
   always_comb begin
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      lock_d     = lock_q;
      wdf_done_d = wdf_done_q;
      if (accept) begin
         lock_d     = 1'b0;
         wdf_done_d = 1'b0;
         if (eff == owner_q) begin
            cnt_d = (cnt_q >= CNT_W'(MAX_BURST)) ? CNT_W'(MAX_BURST) : cnt_q + CNT_W'(1);
         end else begin
            owner_d = eff;
            cnt_d   = CNT_W'(1);
         end
      end else begin
         if (app_en || app_wdf_wren) begin
            owner_d = eff;
            lock_d  = 1'b1;
         end
         if (app_wdf_wren && app_wdf_rdy) begin
            wdf_done_d = 1'b1;
         end
      end
   end

   // Calibration FSM; a locked command finishes before dropping back to CALIB
   always_ff @(posedge ddr4_ui_clk) begin
      if (ddr4_ui_clk_sync_rst) begin
         state_q <= ST_CALIB;
      end else begin
         case (state_q)
            ST_CALIB: if (init_calib_complete) state_q <= ST_RUN;
            ST_RUN:   if (!init_calib_complete && !lock_d) state_q <= ST_CALIB;
            default:  state_q <= ST_CALIB;
         endcase
      end
   end

   // Arbitration state registers
   always_ff @(posedge ddr4_ui_clk) begin
      if (ddr4_ui_clk_sync_rst) begin
         owner_q    <= 1'b0;
         cnt_q      <= '0;
         lock_q     <= 1'b0;
         wdf_done_q <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         lock_q     <= lock_d;
         wdf_done_q <= wdf_done_d;
      end
   end

   // Tag FIFO recording which requester owns each outstanding read
   always_ff @(posedge ddr4_ui_clk) begin
      if (ddr4_ui_clk_sync_rst) begin
         tag_mem_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         tag_cnt_q <= '0;
      end else begin
         if (push) begin
            tag_mem_q[wr_ptr_q] <= eff;
            wr_ptr_q            <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   tag_cnt_q <= tag_cnt_q + TCNT_W'(1);
            2'b01:   tag_cnt_q <= tag_cnt_q - TCNT_W'(1);
            default: tag_cnt_q <= tag_cnt_q;
         endcase
      end
   end

   // Read return routing, one cycle behind the controller; sticky underflow flag
   always_ff @(posedge ddr4_ui_clk) begin
      if (ddr4_ui_clk_sync_rst) begin
         rsp_vld_q  <= 2'b00;
         rsp_data_q <= '0;
         err_q      <= 1'b0;
      end else begin
         rsp_vld_q <= 2'b00;
         if (app_rd_data_valid) begin
            if (tag_cnt_q != '0) begin
               rsp_vld_q  <= head ? 2'b10 : 2'b01;
               rsp_data_q <= app_rd_data;
            end else begin
               err_q <= 1'b1;
            end
         end
      end
   end

   assign rsp_rd_valid      = rsp_vld_q;
   assign rsp_rd_data       = rsp_data_q;
   assign err_tag_underflow = err_q;
   assign app_hi_pri        = 1'b0;

endmodule

// File: tb/tb_ddr4_app_arbiter.sv
// Directed bench for ddr4_app_arbiter: calibration gating, fairness, tag-full
// stall, read routing, write backpressure, underflow and mid-write reset.
module tb_ddr4_app_arbiter;

   localparam int unsigned AW = 31;
   localparam int unsigned DW = 512;
   localparam int unsigned MW = 64;

   logic            clk = 1'b0;
   logic            rst;
   logic            calib;
   logic [1:0]      req, req_rd;
   logic [2*AW-1:0] req_addr;
   logic [2*DW-1:0] req_wdata;
   logic [2*MW-1:0] req_wmask;
   logic [1:0]      req_ack;
   logic [DW-1:0]   rsp_rd_data;
   logic [1:0]      rsp_rd_valid;
   logic            app_en, app_hi_pri, app_rdy;
   logic [2:0]      app_cmd;
   logic [AW-1:0]   app_addr;
   logic [DW-1:0]   app_wdf_data;
   logic [MW-1:0]   app_wdf_mask;
   logic            app_wdf_wren, app_wdf_end, app_wdf_rdy;
   logic [DW-1:0]   app_rd_data;
   logic            app_rd_data_valid;
   logic            err_tag_underflow;

   int n_chk  = 0;
   int n_pass = 0;

   ddr4_app_arbiter dut (
      .ddr4_ui_clk          (clk),
      .ddr4_ui_clk_sync_rst (rst),
      .init_calib_complete  (calib),
      .req                  (req),
      .req_rd               (req_rd),
      .req_addr             (req_addr),
      .req_wdata            (req_wdata),
      .req_wmask            (req_wmask),
      .req_ack              (req_ack),
      .rsp_rd_data          (rsp_rd_data),
      .rsp_rd_valid         (rsp_rd_valid),
      .app_en               (app_en),
      .app_cmd              (app_cmd),
      .app_addr             (app_addr),
      .app_hi_pri           (app_hi_pri),
      .app_rdy              (app_rdy),
      .app_wdf_data         (app_wdf_data),
      .app_wdf_mask         (app_wdf_mask),
      .app_wdf_wren         (app_wdf_wren),
      .app_wdf_end          (app_wdf_end),
      .app_wdf_rdy          (app_wdf_rdy),
      .app_rd_data          (app_rd_data),
      .app_rd_data_valid    (app_rd_data_valid),
      .err_tag_underflow    (err_tag_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Tag order left in the FIFO after the fairness run and one early pop
   function automatic logic [1:0] drain_exp(input int k);
      if (k < 7)       return 2'b01;
      else if (k < 15) return 2'b10;
      else if (k < 23) return 2'b01;
      else if (k < 31) return 2'b10;
      else             return 2'b01;
   endfunction

   logic [1:0] route_seq [4];

   initial begin
      route_seq[0] = 2'b01; route_seq[1] = 2'b10;
      route_seq[2] = 2'b10; route_seq[3] = 2'b01;
      rst = 1'b1; calib = 1'b0; req = 2'b00; req_rd = 2'b00;
      req_addr  = {AW'(31'h155), AW'(31'h2AA)};
      req_wdata = {{8{64'hB1B1_0000_0000_0001}}, {8{64'hA0A0_0000_0000_0000}}};
      req_wmask = {64'h0000_0000_0000_00F0, 64'h0000_0000_0000_000F};
      app_rdy = 1'b0; app_wdf_rdy = 1'b0;
      app_rd_data = '0; app_rd_data_valid = 1'b0;

      // Reset state
      repeat (3) tick();
      chk("rst_en",    64'(app_en), 64'd0);
      chk("rst_wren",  64'(app_wdf_wren), 64'd0);
      chk("rst_ack",   64'(req_ack), 64'd0);
      chk("rst_rsp",   64'(rsp_rd_valid), 64'd0);
      chk("rst_err",   64'(err_tag_underflow), 64'd0);
      chk("rst_hipri", 64'(app_hi_pri), 64'd0);

      // Nothing issues before calibration
      rst = 1'b0; req = 2'b11; req_rd = 2'b11; app_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         chk("calib_en",  64'(app_en), 64'd0);
         chk("calib_ack", 64'(req_ack), 64'd0);
         tick();
      end
      calib = 1'b1;
      #1 chk("calib_edge_en", 64'(app_en), 64'd0);
      tick();

      // Fairness: 8 acks to req0, 8 to req1, repeating
      for (int i = 0; i < 32; i++) begin
         #1;
         chk("fair_ack", 64'(req_ack), ((i / 8) % 2 == 0) ? 64'd1 : 64'd2);
         if (i == 0) chk("fair_cmd", 64'(app_cmd), 64'd1);
         tick();
      end

      // Tag FIFO full: read stalls, including the cycle of the pop
      #1;
      chk("full_en",  64'(app_en), 64'd0);
      chk("full_ack", 64'(req_ack), 64'd0);
      tick();
      app_rd_data_valid = 1'b1; app_rd_data = DW'(64'hD0);
      #1 chk("full_pop_en", 64'(app_en), 64'd0);
      tick();
      app_rd_data_valid = 1'b0;
      #1;
      chk("full_rsp",  64'(rsp_rd_valid), 64'd1);
      chk("full_data", 64'(rsp_rd_data), 64'hD0);
      chk("full_en1",  64'(app_en), 64'd1);
      chk("full_ack1", 64'(req_ack), 64'd1);
      tick();

      // Drain all outstanding reads in order
      req = 2'b00;
      for (int k = 0; k <= 32; k++) begin
         app_rd_data_valid = (k < 32);
         app_rd_data       = DW'(64'h1000 + 64'(k));
         #1;
         if (k > 0) begin
            chk("drain_rsp",  64'(rsp_rd_valid), 64'(drain_exp(k - 1)));
            chk("drain_data", 64'(rsp_rd_data), 64'h1000 + 64'(k - 1));
         end
         tick();
      end
      app_rd_data_valid = 1'b0;
      #1 chk("drain_idle", 64'(rsp_rd_valid), 64'd0);

      // Read routing req0, req1, req1, req0 (lone requesters, no bubbles)
      for (int j = 0; j < 4; j++) begin
         req = route_seq[j];
         #1 chk("route_ack", 64'(req_ack), 64'(route_seq[j]));
         tick();
      end
      req = 2'b00;
      for (int j = 0; j <= 4; j++) begin
         app_rd_data_valid = (j < 4);
         app_rd_data       = DW'(64'hA0 + 64'(j));
         #1;
         if (j > 0) begin
            chk("route_rsp",  64'(rsp_rd_valid), 64'(route_seq[j - 1]));
            chk("route_data", 64'(rsp_rd_data), 64'hA0 + 64'(j - 1));
         end
         tick();
      end
      app_rd_data_valid = 1'b0;

      // Write backpressure from req1; req0 arriving mid-stall must not steal
      app_rdy = 1'b0; app_wdf_rdy = 1'b1; req_rd = 2'b00; req = 2'b10;
      for (int c = 0; c <= 5; c++) begin
         if (c == 2) req = 2'b11;
         app_rdy = (c == 5);
         #1;
         chk("bp_wren", 64'(app_wdf_wren), (c == 0) ? 64'd1 : 64'd0);
         chk("bp_en",   64'(app_en), 64'd1);
         chk("bp_addr", 64'(app_addr), 64'h155);
         chk("bp_data", 64'(app_wdf_data), 64'hB1B1_0000_0000_0001);
         chk("bp_ack",  64'(req_ack), (c == 5) ? 64'd2 : 64'd0);
         if (c == 0) begin
            chk("bp_cmd",  64'(app_cmd), 64'd0);
            chk("bp_mask", 64'(app_wdf_mask), 64'hF0);
            chk("bp_end",  64'(app_wdf_end), 64'd1);
         end
         tick();
      end
      req = 2'b01;
      #1;
      chk("wr0_ack",  64'(req_ack), 64'd1);
      chk("wr0_wren", 64'(app_wdf_wren), 64'd1);
      chk("wr0_addr", 64'(app_addr), 64'h2AA);
      tick();
      req = 2'b00;

      // Read data with an empty tag FIFO
      app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0;
      #1;
      chk("uf_err", 64'(err_tag_underflow), 64'd1);
      chk("uf_rsp", 64'(rsp_rd_valid), 64'd0);
      tick();
      #1 chk("uf_sticky", 64'(err_tag_underflow), 64'd1);

      // Reset in the middle of a locked write
      app_rdy = 1'b0; req = 2'b10; req_rd = 2'b00;
      #1 chk("mr_wren0", 64'(app_wdf_wren), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mr_en",   64'(app_en), 64'd0);
      chk("mr_wren", 64'(app_wdf_wren), 64'd0);
      chk("mr_ack",  64'(req_ack), 64'd0);
      chk("mr_rsp",  64'(rsp_rd_valid), 64'd0);
      chk("mr_err",  64'(err_tag_underflow), 64'd0);
      tick();
      #1;
      chk("mr_run_en",   64'(app_en), 64'd1);
      chk("mr_run_wren", 64'(app_wdf_wren), 64'd1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
